// File: rtl/opl3_pkg.sv
// opl3_pkg -- shared definitions for the YMF262 (OPL3) write scheduler.
//
// Contents:
//   wr_state_t          : write-sequencer states
//   DEF_*_CYC           : default timing, in clk28 cycles
//   ym_addr()           : builds the two-bit YMF262 address {bank, a0}
//   load_val()          : converts a state length into a down-counter load
package opl3_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_STRB  = 3'd2,
    A_WAIT  = 3'd3,
    D_SETUP = 3'd4,
    D_STRB  = 3'd5,
    D_WAIT  = 3'd6
  } wr_state_t;

  localparam int unsigned DEF_STROBE_CYC    = 32'd4;
  localparam int unsigned DEF_ADDR_WAIT_CYC = 32'd64;  // 32 YMF262 clocks
  localparam int unsigned DEF_DATA_WAIT_CYC = 32'd64;

  // a0 = 0 selects the register-index latch, a0 = 1 the data latch.
  function automatic logic [1:0] ym_addr(input logic bank, input logic is_data);
    return {bank, is_data};
  endfunction

  // The counter is loaded with (length - 1) and the state ends when it reads zero.
  function automatic logic [7:0] load_val(input int unsigned cycles);
    return 8'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/opl3_rr_arb2.sv
// opl3_rr_arb2 -- two-requester round-robin arbiter (purely combinational).
//
// Ports:
//   req[1:0]   : active requests
//   last_grant : index of the requester granted most recently
//   grant[1:0] : one-hot grant, all-zero when nobody requests
module opl3_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On contention the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/opl3_wr_sched.sv
// opl3_wr_sched -- arbitrates two write requesters onto a YMF262 bus and
// sequences each write as address cycle, address recovery, data cycle, data
// recovery.
//
// Ports:
//   clk28, rst            : clock and synchronous active-high reset
//   req0/1                : write request (0 = host port, 1 = init sequencer),
//                           held until the matching ack
//   bank0/1, reg0/1, dat0/1 : OPL3 bank, register index and data per requester
//   ack0/1                : one-cycle acceptance pulse, same cycle as the grant
//   ym_cs_n, ym_wr_n, ym_a, ym_d, ym_d_oe : registered YMF262 bus
//   busy                  : high whenever a write is in progress
//   wr_cnt                : completed-write counter (only with
//                           OPL3_WR_SCHED_STATS_EN defined)
//
// Build option: define OPL3_WR_SCHED_STATS_EN to add the wr_cnt port.
module opl3_wr_sched
  import opl3_pkg::*;
#(
  parameter int unsigned STROBE_CYC    = DEF_STROBE_CYC,
  parameter int unsigned ADDR_WAIT_CYC = DEF_ADDR_WAIT_CYC,
  parameter int unsigned DATA_WAIT_CYC = DEF_DATA_WAIT_CYC
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        bank0,
  input  logic        bank1,
  input  logic [7:0]  reg0,
  input  logic [7:0]  reg1,
  input  logic [7:0]  dat0,
  input  logic [7:0]  dat1,
  output logic        ack0,
  output logic        ack1,
  output logic        ym_cs_n,
  output logic        ym_wr_n,
  output logic [1:0]  ym_a,
  output logic [7:0]  ym_d,
  output logic        ym_d_oe,
`ifdef OPL3_WR_SCHED_STATS_EN
  output logic [15:0] wr_cnt,
`endif
  output logic        busy
);

  localparam logic [7:0] STRB_LOAD = load_val(STROBE_CYC);
  localparam logic [7:0] AW_LOAD   = load_val(ADDR_WAIT_CYC);
  localparam logic [7:0] DW_LOAD   = load_val(DATA_WAIT_CYC);

  wr_state_t  state;
  wr_state_t  next_state;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic [1:0] arb_req;
  logic [1:0] grant;
  logic       last_grant;
  logic       lat_bank;
  logic [7:0] lat_dat;
  logic       sel_bank;
  logic [7:0] sel_reg;
  logic [7:0] sel_dat;
  logic       cs_next;
  logic       wr_next;
  logic       oe_next;
  logic [1:0] a_next;
  logic [7:0] d_next;

  // Requests are only considered in IDLE and never while reset is asserted.
  always_comb begin
    if ((state == IDLE) && !rst) begin
      arb_req = {req1, req0};
    end else begin
      arb_req = 2'b00;
    end
  end

  opl3_rr_arb2 u_arb (
    .req        (arb_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign ack0 = grant[0];
  assign ack1 = grant[1];

  // Fields of the requester being granted this cycle.
  always_comb begin
    if (grant[1]) begin
      sel_bank = bank1;
      sel_reg  = reg1;
      sel_dat  = dat1;
    end else begin
      sel_bank = bank0;
      sel_reg  = reg0;
      sel_dat  = dat0;
    end
  end

  // Next state and shared down-counter; the counter is reloaded on each state entry.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (|grant) begin
          next_state = A_SETUP;
          cnt_next   = 8'd0;
        end else begin
          next_state = IDLE;
          cnt_next   = 8'd0;
        end
      end
      A_SETUP: begin
        next_state = A_STRB;
        cnt_next   = STRB_LOAD;
      end
      A_STRB: begin
        if (cnt == 8'd0) begin
          next_state = A_WAIT;
          cnt_next   = AW_LOAD;
        end else begin
          next_state = A_STRB;
          cnt_next   = cnt - 8'd1;
        end
      end
      A_WAIT: begin
        if (cnt == 8'd0) begin
          next_state = D_SETUP;
          cnt_next   = 8'd0;
        end else begin
          next_state = A_WAIT;
          cnt_next   = cnt - 8'd1;
        end
      end
      D_SETUP: begin
        next_state = D_STRB;
        cnt_next   = STRB_LOAD;
      end
      D_STRB: begin
        if (cnt == 8'd0) begin
          next_state = D_WAIT;
          cnt_next   = DW_LOAD;
        end else begin
          next_state = D_STRB;
          cnt_next   = cnt - 8'd1;
        end
      end
      D_WAIT: begin
        if (cnt == 8'd0) begin
          next_state = IDLE;
          cnt_next   = 8'd0;
        end else begin
          next_state = D_WAIT;
          cnt_next   = cnt - 8'd1;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Bus values for the state being entered. ym_a/ym_d only load on SETUP
  // entry and otherwise hold, so they cannot move during a strobe.
  always_comb begin
    cs_next = 1'b1;
    wr_next = 1'b1;
    oe_next = 1'b0;
    a_next  = ym_a;
    d_next  = ym_d;
    case (next_state)
      A_SETUP: begin
        cs_next = 1'b0;
        oe_next = 1'b1;
        a_next  = ym_addr(sel_bank, 1'b0);
        d_next  = sel_reg;
      end
      A_STRB: begin
        cs_next = 1'b0;
        wr_next = 1'b0;
        oe_next = 1'b1;
      end
      D_SETUP: begin
        cs_next = 1'b0;
        oe_next = 1'b1;
        a_next  = ym_addr(lat_bank, 1'b1);
        d_next  = lat_dat;
      end
      D_STRB: begin
        cs_next = 1'b0;
        wr_next = 1'b0;
        oe_next = 1'b1;
      end
      default: begin
        cs_next = 1'b1;
        wr_next = 1'b1;
        oe_next = 1'b0;
      end
    endcase
  end

  // State, counter, latched request and registered bus outputs.
  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      lat_bank   <= 1'b0;
      lat_dat    <= 8'd0;
      ym_cs_n    <= 1'b1;
      ym_wr_n    <= 1'b1;
      ym_d_oe    <= 1'b0;
      ym_a       <= 2'd0;
      ym_d       <= 8'd0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      busy    <= (next_state != IDLE);
      ym_cs_n <= cs_next;
      ym_wr_n <= wr_next;
      ym_d_oe <= oe_next;
      ym_a    <= a_next;
      ym_d    <= d_next;
      if (|grant) begin
        last_grant <= grant[1];
        lat_bank   <= sel_bank;
        lat_dat    <= sel_dat;
      end else begin
        last_grant <= last_grant;
        lat_bank   <= lat_bank;
        lat_dat    <= lat_dat;
      end
    end
  end

`ifdef OPL3_WR_SCHED_STATS_EN
  // Counts writes whose data strobe completed (entry into D_WAIT).
  always_ff @(posedge clk28) begin
    if (rst) begin
      wr_cnt <= 16'd0;
    end else if ((next_state == D_WAIT) && (state != D_WAIT)) begin
      wr_cnt <= wr_cnt + 16'd1;
    end else begin
      wr_cnt <= wr_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_opl3_wr_sched.sv
module tb_opl3_wr_sched;

  localparam int S     = 4;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int TOTAL = 2 + 2 * S + AW + DW;  // cycles a write keeps the bus busy
  localparam int DSET  = 2 + S + AW;           // offset (from ack) of the data setup cycle

  logic        clk28 = 1'b0;
  logic        rst;
  logic        req0, req1, bank0, bank1;
  logic [7:0]  reg0, reg1, dat0, dat1;
  logic        ack0, ack1, ym_cs_n, ym_wr_n, ym_d_oe, busy;
  logic [1:0]  ym_a;
  logic [7:0]  ym_d;
`ifdef OPL3_WR_SCHED_STATS_EN
  logic [15:0] wr_cnt;
`endif

  always #5 clk28 = ~clk28;

  opl3_wr_sched dut (
    .clk28 (clk28), .rst (rst),
    .req0 (req0), .req1 (req1),
    .bank0 (bank0), .bank1 (bank1),
    .reg0 (reg0), .reg1 (reg1),
    .dat0 (dat0), .dat1 (dat1),
    .ack0 (ack0), .ack1 (ack1),
    .ym_cs_n (ym_cs_n), .ym_wr_n (ym_wr_n),
    .ym_a (ym_a), .ym_d (ym_d), .ym_d_oe (ym_d_oe),
`ifdef OPL3_WR_SCHED_STATS_EN
    .wr_cnt (wr_cnt),
`endif
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a write is tracked only as its offset from the ack cycle.
  int         m_k;       // 0 = idle, 1..TOTAL = cycles since ack
  int         m_prio;    // requester that wins the next contention
  logic       m_bank;
  logic [7:0] m_reg, m_dat;
  logic [1:0] m_a;
  logic [7:0] m_d;
  int         m_wr_cnt;

  // {ack1, ack0, busy, cs_n, wr_n, d_oe, a[1:0], d[7:0]}
  logic [15:0] act_vec, exp_vec;

  task automatic model_reset();
    m_k = 0; m_prio = 0; m_a = 2'b00; m_d = 8'h00; m_wr_cnt = 0;
    m_bank = 1'b0; m_reg = 8'h00; m_dat = 8'h00;
  endtask

  // Inputs for this cycle are already applied: sample DUT, build expectation,
  // advance the model, move to the next falling edge.
  task automatic step();
    int   win;
    logic in_bus, in_strb;
    logic e_ack0, e_ack1;
    #1;
    act_vec = {ack1, ack0, busy, ym_cs_n, ym_wr_n, ym_d_oe, ym_a, ym_d};
    win = -1;
    if (m_k == 0 && !rst) begin
      if (req0 && req1) win = m_prio;
      else if (req0)    win = 0;
      else if (req1)    win = 1;
    end
    e_ack0 = (win == 0);
    e_ack1 = (win == 1);
    if (m_k == 1)    begin m_a = {m_bank, 1'b0}; m_d = m_reg; end
    if (m_k == DSET) begin m_a = {m_bank, 1'b1}; m_d = m_dat; end
    in_bus  = (m_k >= 1 && m_k <= 1 + S) || (m_k >= DSET && m_k <= DSET + S);
    in_strb = (m_k >= 2 && m_k <= 1 + S) || (m_k >= DSET + 1 && m_k <= DSET + S);
    exp_vec = {e_ack1, e_ack0, (m_k != 0), !in_bus, !in_strb, in_bus, m_a, m_d};
    if (rst) begin
      model_reset();
    end else if (win >= 0) begin
      m_k    = 1;
      m_bank = (win == 0) ? bank0 : bank1;
      m_reg  = (win == 0) ? reg0  : reg1;
      m_dat  = (win == 0) ? dat0  : dat1;
      m_prio = (win == 0) ? 1 : 0;
    end else if (m_k != 0) begin
      if (m_k == DSET + S) m_wr_cnt++;
      m_k = (m_k == TOTAL) ? 0 : m_k + 1;
    end
    cyc++;
    @(negedge clk28);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (act_vec !== 16'h1800) begin
        errors++;
        $display("FAIL reset_values: got %h expected %h", act_vec, 16'h1800);
      end
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_model: got %h expected %h", act_vec, exp_vec);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int nack = 0, ack_at = -1, strb_a = 0, strb_d = 0, busy_low = -1;
    req1 = 1'b0; req0 = 1'b1; bank0 = 1'b1; reg0 = 8'h05; dat0 = 8'h01;
    for (int i = 0; i < TOTAL + 8; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL single_write cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (act_vec[14]) begin nack++; ack_at = i; req0 = 1'b0; end
      if (!act_vec[11] && act_vec[9:8] == 2'b10 && act_vec[7:0] == 8'h05) strb_a++;
      if (!act_vec[11] && act_vec[9:8] == 2'b11 && act_vec[7:0] == 8'h01) strb_d++;
      if (ack_at >= 0 && i > ack_at && !act_vec[13] && busy_low < 0) busy_low = i - ack_at;
    end
    checks++;
    if (nack != 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", nack); end
    checks++;
    if (strb_a != 4) begin errors++; $display("FAIL single_addr_strobe: got %0d cycles expected 4", strb_a); end
    checks++;
    if (strb_d != 4) begin errors++; $display("FAIL single_data_strobe: got %0d cycles expected 4", strb_d); end
    checks++;
    if (busy_low != 139) begin errors++; $display("FAIL single_busy_len: busy fell at %0d expected 139", busy_low); end
  endtask

  task automatic test_contention();
    int order[$];
    int exp_order[4] = '{0, 1, 0, 1};
    rst = 1'b1;
    step();
    checks++;
    if (act_vec !== exp_vec) begin errors++; $display("FAIL contention_reset: got %h expected %h", act_vec, exp_vec); end
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    bank0 = 1'($urandom); reg0 = 8'($urandom); dat0 = 8'($urandom);
    bank1 = 1'($urandom); reg1 = 8'($urandom); dat1 = 8'($urandom);
    for (int i = 0; i < 4 * (TOTAL + 1) + 10; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL contention cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (act_vec[14]) begin order.push_back(0); reg0 = 8'($urandom); dat0 = 8'($urandom); bank0 = 1'($urandom); end
      if (act_vec[15]) begin order.push_back(1); reg1 = 8'($urandom); dat1 = 8'($urandom); bank1 = 1'($urandom); end
      if (order.size() >= 4) begin req0 = 1'b0; req1 = 1'b0; end
    end
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL contention_count: got %0d grants expected 4", order.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (order[j] != exp_order[j]) begin
          errors++;
          $display("FAIL contention_order[%0d]: got requester %0d expected %0d", j, order[j], exp_order[j]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks[$];
    req0 = 1'b0; req1 = 1'b1;
    bank1 = 1'b0; reg1 = 8'hB0; dat1 = 8'h21;
    for (int i = 0; i < 3 * (TOTAL + 1) + 10; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (act_vec[15]) begin
        acks.push_back(i);
        reg1 = reg1 + 8'd1; dat1 = 8'($urandom);
        if (acks.size() >= 3) req1 = 1'b0;
      end
    end
    checks++;
    if (acks.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks expected 3", acks.size());
    end else begin
      for (int j = 1; j < 3; j++) begin
        checks++;
        if (acks[j] - acks[j-1] != 139) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d expected 139", j, acks[j] - acks[j-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    int nack = 0;
    req1 = 1'b0; req0 = 1'b1; bank0 = 1'($urandom); reg0 = 8'($urandom); dat0 = 8'($urandom);
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_pre cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (act_vec[14]) req0 = 1'b0;
      if (m_k == DSET + 2) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_reach: got no D_STRB within 200 cycles expected one"); end
    rst = 1'b1;
    step();
    checks++;
    if (act_vec[11] !== 1'b0) begin errors++; $display("FAIL reset_mid_in_strobe: got wr_n %b expected 0", act_vec[11]); end
    rst = 1'b0;
    step();
    checks++;
    if (act_vec[13:10] !== 4'b0110) begin
      errors++;
      $display("FAIL reset_mid_abort: got busy/cs_n/wr_n/oe %b expected 0110", act_vec[13:10]);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid_post cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (act_vec[15:14] != 2'b00) nack++;
    end
    checks++;
    if (nack != 0) begin errors++; $display("FAIL reset_mid_reack: got %0d acks expected 0", nack); end
  endtask

  task automatic test_dropped();
    int nack0 = 0;
    req0 = 1'b0; req1 = 1'b1; bank1 = 1'b1; reg1 = 8'h3C; dat1 = 8'h5A;
    bank0 = 1'b0; reg0 = 8'hEE; dat0 = 8'hEE;
    for (int i = 0; i < TOTAL + 10; i++) begin
      req0 = (i >= 20 && i < 31) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL dropped cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (act_vec[15]) req1 = 1'b0;
      if (act_vec[14]) nack0++;
    end
    checks++;
    if (nack0 != 0) begin errors++; $display("FAIL dropped_ack0: got %0d acks expected 0", nack0); end
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0;
    int bad = 0;
    for (int i = 0; i < 2500; i++) begin
      if (!p0 && $urandom_range(0, 7) == 0) begin
        p0 = 1; bank0 = 1'($urandom); reg0 = 8'($urandom); dat0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 7) == 0) begin
        p1 = 1; bank1 = 1'($urandom); reg1 = 8'($urandom); dat1 = 8'($urandom);
      end
      if (p0 && m_k != 0 && $urandom_range(0, 99) == 0) p0 = 0;
      req0 = p0; req1 = p1;
      rst  = ($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++; bad++;
        if (bad < 20) $display("FAIL random cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
      if (act_vec[14]) p0 = 0;
      if (act_vec[15]) p1 = 0;
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < TOTAL + 2; i++) begin
      step();
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_drain cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
    end
  endtask

`ifdef OPL3_WR_SCHED_STATS_EN
  task automatic test_stats();
    checks++;
    if (wr_cnt !== 16'(m_wr_cnt)) begin
      errors++;
      $display("FAIL stats_wr_cnt: got %0d expected %0d", wr_cnt, 16'(m_wr_cnt));
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bank0 = 1'b0; bank1 = 1'b0;
    reg0 = 8'h00; reg1 = 8'h00; dat0 = 8'h00; dat1 = 8'h00;
    repeat (2) @(negedge clk28);
    model_reset();
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_dropped();
    test_random();
`ifdef OPL3_WR_SCHED_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
